// File: rtl/mem_pkg.sv
// Shared types and default sizing for the line-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    localparam int LINE_W  = 128;
    localparam int DEPTH   = 64;
    localparam int LATENCY = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_resp_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

endpackage

// File: rtl/mem_line_array.sv
// Line storage: DEPTH lines of LINE_W bits, one write port and one read port.
// Latency: write lands on the enabled edge; read data registered on the enabled edge.
// Backpressure: none, both ports accept every cycle; contents are never reset.
module mem_line_array
    import mem_pkg::*;
#(
    parameter int LINE_W = mem_pkg::LINE_W,
    parameter int DEPTH  = mem_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_idx,
    input  logic [LINE_W-1:0]        i_wr_dat,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
    output logic [LINE_W-1:0]        o_rd_dat
);

    logic [LINE_W-1:0] r_mem [DEPTH];
    logic [LINE_W-1:0] r_rd_dat;

    // Commit a line when the write port is enabled.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_dat;
        end
    end

    // Capture the addressed line only when asked, so the output holds between reads.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/mem_responder.sv
// Line-memory responder: accepts one read or write-back, holds ca_resp for LATENCY cycles, then completes.
// Latency: ca_resp rises the cycle after acceptance and stays high LATENCY cycles; read data valid when it falls.
// Backpressure: requests are ignored while busy; completion waits for the requester to drop its request.
module mem_responder #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = mem_pkg::LINE_W,
    parameter int DEPTH   = mem_pkg::DEPTH,
    parameter int LATENCY = mem_pkg::LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              ca_resp,
    output logic              error
);
    import mem_pkg::*;

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    mem_resp_state_t   r_state;
    mem_resp_state_t   w_next_state;
    mem_op_t           r_op;
    logic [IDX_W-1:0]  r_idx;
    logic [LINE_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ca_resp;
    logic              r_error;
    logic              r_rd_vld;

    logic              w_accept;
    logic              w_last;
    logic              w_req_held;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [LINE_W-1:0] w_rd_dat;
    logic              w_unused_addr;

    // Offset and upper address bits do not select a line; upper bits alias.
    assign w_unused_addr = ^{mem_addr[ADDR_W-1:OFF_W+IDX_W], mem_addr[OFF_W-1:0]};

    assign w_accept   = (r_state == ST_IDLE) && (mem_read ^ mem_write);
    assign w_last     = (r_state == ST_BUSY) && (r_cnt == CNT_W'(LATENCY - 1));
    assign w_req_held = (r_op == OP_READ) ? mem_read : mem_write;
    assign w_wr_en    = w_last && (r_op == OP_WRITE);
    assign w_rd_en    = w_last && (r_op == OP_READ);

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: DONE lingers until the requester lets go of the completed request.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_next_state = ST_BUSY;
            ST_BUSY: if (w_last)      w_next_state = ST_DONE;
            ST_DONE: if (!w_req_held) w_next_state = ST_IDLE;
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    // Request latches, busy counter, registered response and error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op      <= OP_READ;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_ca_resp <= 1'b0;
            r_error   <= 1'b0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_error <= (r_state == ST_IDLE) && mem_read && mem_write;
            if (w_accept) begin
                r_op      <= mem_write ? OP_WRITE : OP_READ;
                r_idx     <= mem_addr[OFF_W+IDX_W-1:OFF_W];
                r_wdata   <= mem_wdata;
                r_cnt     <= '0;
                r_ca_resp <= 1'b1;
            end else if (r_state == ST_BUSY) begin
                if (w_last) begin
                    r_cnt     <= '0;
                    r_ca_resp <= 1'b0;
                    if (r_op == OP_READ) begin
                        r_rd_vld <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    mem_line_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) u_line_array (
        .clk      (clk),
        .i_wr_en  (w_wr_en),
        .i_wr_idx (r_idx),
        .i_wr_dat (r_wdata),
        .i_rd_en  (w_rd_en),
        .i_rd_idx (r_idx),
        .o_rd_dat (w_rd_dat)
    );

    // The storage read register has no reset, so report zero until a read has completed.
    assign mem_rdata = r_rd_vld ? w_rd_dat : '0;
    assign ca_resp   = r_ca_resp;
    assign error     = r_error;

endmodule
